// File: rtl/mem_req_arbiter.sv
// Arbitrates icache/dcache block requests onto the single main_mem request channel and routes
// read responses back by cache type. Define MEM_REQ_ARB_RR_EN for pure round-robin arbitration.
`ifndef MAIN_MEM_BLOCK_ADDR_WIDTH
`define MAIN_MEM_BLOCK_ADDR_WIDTH 32
`endif
`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 64
`endif

module mem_req_arbiter #(
  parameter int ADDR_W          = `MAIN_MEM_BLOCK_ADDR_WIDTH,
  parameter int DATA_W          = `BLOCK_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic              clk,
  input  logic              rst_aL,
  input  logic              icache_req_valid,
  input  logic [ADDR_W-1:0] icache_req_block_addr,
  output logic              icache_req_ready,
  input  logic              dcache_req_valid,
  input  logic              dcache_req_type,
  input  logic [ADDR_W-1:0] dcache_req_block_addr,
  input  logic [DATA_W-1:0] dcache_req_block_data,
  output logic              dcache_req_ready,
  output logic              mem_req_valid,
  output logic              mem_req_cache_type,
  output logic              mem_req_type,
  output logic [ADDR_W-1:0] mem_req_block_addr,
  output logic [DATA_W-1:0] mem_req_block_data,
  input  logic              mem_resp_valid,
  input  logic              mem_resp_cache_type,
  input  logic [DATA_W-1:0] mem_resp_block_data,
  output logic              icache_resp_valid,
  output logic [DATA_W-1:0] icache_resp_block_data,
  output logic              dcache_resp_valid,
  output logic [DATA_W-1:0] dcache_resp_block_data,
  output logic              protocol_err
);

  localparam int               CNT_W   = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] r_outstanding;
  logic             r_protocol_err;
  logic             w_full;
  logic             w_i_ok;
  logic             w_d_ok;
  logic             w_i_prio;
  logic             w_grant_i;
  logic             w_grant_d;
  logic             w_accept_read;
  logic             w_resp_dec;

  // A write bypasses the capacity check, so it can overtake a blocked read.
  assign w_full    = (r_outstanding == MAX_CNT);
  assign w_i_ok    = icache_req_valid & ~w_full;
  assign w_d_ok    = dcache_req_valid & (dcache_req_type | ~w_full);
  assign w_grant_i = w_i_ok & (w_i_prio | ~w_d_ok);
  assign w_grant_d = w_d_ok & (~w_i_prio | ~w_i_ok);

  assign w_accept_read = w_grant_i | (w_grant_d & ~dcache_req_type);
  assign w_resp_dec    = mem_resp_valid & (r_outstanding != '0);

`ifdef MEM_REQ_ARB_RR_EN
  logic r_last_d;

  assign w_i_prio = r_last_d;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_last_d <= 1'b0;
    end else if (w_grant_i) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end
  end
`else
  typedef enum logic {ARB, ICACHE_PRIO} state_t;

  localparam logic [7:0] STARVE_CNT = 8'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_starve;
  logic [7:0] w_starve_nxt;

  assign w_i_prio = (r_state == ICACHE_PRIO);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    case (r_state)
      ARB: begin
        if (icache_req_valid && !w_grant_i) begin
          w_starve_nxt = r_starve + 8'd1;
          if (w_starve_nxt == STARVE_CNT) w_state_nxt = ICACHE_PRIO;
        end else begin
          w_starve_nxt = '0;
        end
      end
      ICACHE_PRIO: begin
        if (w_grant_i || !icache_req_valid) begin
          w_starve_nxt = '0;
          w_state_nxt  = ARB;
        end
      end
      default: begin
        w_starve_nxt = '0;
        w_state_nxt  = ARB;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_state  <= ARB;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      mem_req_valid      <= 1'b0;
      mem_req_cache_type <= 1'b0;
      mem_req_type       <= 1'b0;
      mem_req_block_addr <= '0;
      mem_req_block_data <= '0;
    end else begin
      mem_req_valid <= w_grant_i | w_grant_d;
      if (w_grant_d) begin
        mem_req_cache_type <= 1'b1;
        mem_req_type       <= dcache_req_type;
        mem_req_block_addr <= dcache_req_block_addr;
        mem_req_block_data <= dcache_req_block_data;
      end else if (w_grant_i) begin
        mem_req_cache_type <= 1'b0;
        mem_req_type       <= 1'b0;
        mem_req_block_addr <= icache_req_block_addr;
        mem_req_block_data <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_outstanding  <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      case ({w_accept_read, w_resp_dec})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (mem_resp_valid && (r_outstanding == '0)) r_protocol_err <= 1'b1;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign icache_req_ready       = rst_aL & w_grant_i;
  assign dcache_req_ready       = rst_aL & w_grant_d;
  assign icache_resp_valid      = rst_aL & mem_resp_valid & ~mem_resp_cache_type;
  assign dcache_resp_valid      = rst_aL & mem_resp_valid & mem_resp_cache_type;
  assign icache_resp_block_data = {DATA_W{rst_aL}} & mem_resp_block_data;
  assign dcache_resp_block_data = {DATA_W{rst_aL}} & mem_resp_block_data;
  assign protocol_err           = r_protocol_err;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a vector table for single-cycle behaviour, then hand
// sequences for starvation/round-robin, capacity, simultaneous accept+response, errors and reset.
module tb_mem_req_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_aL = 1'b0;
  logic          icache_req_valid;
  logic [AW-1:0] icache_req_block_addr;
  logic          icache_req_ready;
  logic          dcache_req_valid;
  logic          dcache_req_type;
  logic [AW-1:0] dcache_req_block_addr;
  logic [DW-1:0] dcache_req_block_data;
  logic          dcache_req_ready;
  logic          mem_req_valid;
  logic          mem_req_cache_type;
  logic          mem_req_type;
  logic [AW-1:0] mem_req_block_addr;
  logic [DW-1:0] mem_req_block_data;
  logic          mem_resp_valid;
  logic          mem_resp_cache_type;
  logic [DW-1:0] mem_resp_block_data;
  logic          icache_resp_valid;
  logic [DW-1:0] icache_resp_block_data;
  logic          dcache_resp_valid;
  logic [DW-1:0] dcache_resp_block_data;
  logic          protocol_err;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst_aL(rst_aL),
    .icache_req_valid(icache_req_valid), .icache_req_block_addr(icache_req_block_addr),
    .icache_req_ready(icache_req_ready),
    .dcache_req_valid(dcache_req_valid), .dcache_req_type(dcache_req_type),
    .dcache_req_block_addr(dcache_req_block_addr), .dcache_req_block_data(dcache_req_block_data),
    .dcache_req_ready(dcache_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_cache_type(mem_req_cache_type),
    .mem_req_type(mem_req_type), .mem_req_block_addr(mem_req_block_addr),
    .mem_req_block_data(mem_req_block_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_cache_type(mem_resp_cache_type),
    .mem_resp_block_data(mem_resp_block_data),
    .icache_resp_valid(icache_resp_valid), .icache_resp_block_data(icache_resp_block_data),
    .dcache_resp_valid(dcache_resp_valid), .dcache_resp_block_data(dcache_resp_block_data),
    .protocol_err(protocol_err)
  );

  typedef struct {
    logic          iv;
    logic [AW-1:0] ia;
    logic          dv;
    logic          dt;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    logic          rv;
    logic          rt;
    logic [DW-1:0] rd;
    logic          e_ir;
    logic          e_dr;
    logic          e_irv;
    logic          e_drv;
    logic          e_mv;
    logic          e_mct;
    logic          e_mt;
    logic [AW-1:0] e_ma;
    logic [DW-1:0] e_md;
    logic          e_err;
  } vec_t;

  vec_t vecs [9];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    icache_req_valid      = 1'b0;
    icache_req_block_addr = '0;
    dcache_req_valid      = 1'b0;
    dcache_req_type       = 1'b0;
    dcache_req_block_addr = '0;
    dcache_req_block_data = '0;
    mem_resp_valid        = 1'b0;
    mem_resp_cache_type   = 1'b0;
    mem_resp_block_data   = '0;
  endtask

  task automatic d_read_cycle(input logic [AW-1:0] addr, input logic rv, input logic exp_rdy,
                              input string name);
    @(negedge clk);
    idle_inputs();
    dcache_req_valid      = 1'b1;
    dcache_req_block_addr = addr;
    mem_resp_valid        = rv;
    mem_resp_cache_type   = 1'b1;
    #1;
    check(name, dcache_req_ready, exp_rdy);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_inputs();
      mem_resp_valid      = 1'b1;
      mem_resp_cache_type = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("drain err", protocol_err, 1'b0);
  endtask

  task automatic all_zero(input string name);
    check({name, " ir"}, icache_req_ready, 1'b0);
    check({name, " dr"}, dcache_req_ready, 1'b0);
    check({name, " mv"}, mem_req_valid, 1'b0);
    check({name, " ma"}, mem_req_block_addr, '0);
    check({name, " irv"}, icache_resp_valid, 1'b0);
    check({name, " drv"}, dcache_resp_valid, 1'b0);
    check({name, " ird"}, icache_resp_block_data, '0);
    check({name, " err"}, protocol_err, 1'b0);
  endtask

  initial begin
    logic exp_i;

    //           iv  ia      dv  dt  da      dd      rv  rt  rd      ir  dr  irv drv mv  mct mt  ma      md      err
    vecs[0] = '{1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  32'h0,  1'b0};
    vecs[1] = '{1'b0, 16'h0,  1'b1, 1'b1, 16'h20, 32'h55, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  32'h0,  1'b0};
    vecs[2] = '{1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h20, 32'h55, 1'b0};
    vecs[3] = '{1'b1, 16'h10, 1'b0, 1'b0, 16'h0,  32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  32'h0,  1'b0};
    vecs[4] = '{1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  32'h0,  1'b1, 1'b0, 32'hAB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h10, 32'h0,  1'b0};
    vecs[5] = '{1'b1, 16'h30, 1'b1, 1'b0, 16'h40, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  32'h0,  1'b0};
    vecs[6] = '{1'b1, 16'h30, 1'b0, 1'b0, 16'h0,  32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h40, 32'h0,  1'b0};
    vecs[7] = '{1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  32'h0,  1'b1, 1'b1, 32'hCD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h30, 32'h0,  1'b0};
    vecs[8] = '{1'b0, 16'h0,  1'b0, 1'b0, 16'h0,  32'h0,  1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  32'h0,  1'b0};

    // Reset held with live inputs: every output must stay low.
    idle_inputs();
    icache_req_valid    = 1'b1;
    dcache_req_valid    = 1'b1;
    mem_resp_valid      = 1'b1;
    mem_resp_block_data = 32'hAB;
    repeat (2) @(negedge clk);
    #1;
    all_zero("rst");
    @(negedge clk);
    idle_inputs();
    rst_aL = 1'b1;

    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      icache_req_valid      = vecs[k].iv;
      icache_req_block_addr = vecs[k].ia;
      dcache_req_valid      = vecs[k].dv;
      dcache_req_type       = vecs[k].dt;
      dcache_req_block_addr = vecs[k].da;
      dcache_req_block_data = vecs[k].dd;
      mem_resp_valid        = vecs[k].rv;
      mem_resp_cache_type   = vecs[k].rt;
      mem_resp_block_data   = vecs[k].rd;
      #1;
      check($sformatf("v%0d ir", k), icache_req_ready, vecs[k].e_ir);
      check($sformatf("v%0d dr", k), dcache_req_ready, vecs[k].e_dr);
      check($sformatf("v%0d irv", k), icache_resp_valid, vecs[k].e_irv);
      check($sformatf("v%0d drv", k), dcache_resp_valid, vecs[k].e_drv);
      check($sformatf("v%0d mv", k), mem_req_valid, vecs[k].e_mv);
      check($sformatf("v%0d err", k), protocol_err, vecs[k].e_err);
      if (vecs[k].e_irv) check($sformatf("v%0d ird", k), icache_resp_block_data, vecs[k].rd);
      if (vecs[k].e_drv) check($sformatf("v%0d drd", k), dcache_resp_block_data, vecs[k].rd);
      if (vecs[k].e_mv) begin
        check($sformatf("v%0d mct", k), mem_req_cache_type, vecs[k].e_mct);
        check($sformatf("v%0d mt", k), mem_req_type, vecs[k].e_mt);
        check($sformatf("v%0d ma", k), mem_req_block_addr, vecs[k].e_ma);
        if (vecs[k].e_mt) check($sformatf("v%0d md", k), mem_req_block_data, vecs[k].e_md);
      end
    end

    // Both caches continuously reading, each read answered the cycle after it issues.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      idle_inputs();
      icache_req_valid      = 1'b1;
      icache_req_block_addr = AW'(16'h100 + k);
      dcache_req_valid      = 1'b1;
      dcache_req_block_addr = AW'(16'h200 + k);
      mem_resp_valid        = mem_req_valid;
      mem_resp_cache_type   = mem_req_cache_type;
      #1;
`ifdef MEM_REQ_ARB_RR_EN
      exp_i = (k % 2 == 1);
`else
      exp_i = (k % 9 == 8);
`endif
      check($sformatf("arb%0d ir", k), icache_req_ready, exp_i);
      check($sformatf("arb%0d dr", k), dcache_req_ready, !exp_i);
    end
    @(negedge clk);
    idle_inputs();
    mem_resp_valid      = mem_req_valid;
    mem_resp_cache_type = mem_req_cache_type;
    @(negedge clk);
    idle_inputs();
    #1;
    check("arb err", protocol_err, 1'b0);

    // Capacity: four reads fill the window, the fifth read blocks, a write still passes.
    for (int k = 0; k < 4; k++) d_read_cycle(AW'(16'h300 + k), 1'b0, 1'b1, $sformatf("cap rd%0d", k));
    @(negedge clk);
    idle_inputs();
    dcache_req_valid = 1'b1;
    icache_req_valid = 1'b1;
    #1;
    check("cap d blocked", dcache_req_ready, 1'b0);
    check("cap i blocked", icache_req_ready, 1'b0);
    @(negedge clk);
    idle_inputs();
    dcache_req_valid      = 1'b1;
    dcache_req_type       = 1'b1;
    dcache_req_block_addr = 16'h2FF;
    dcache_req_block_data = 32'h77;
    #1;
    check("cap wr ready", dcache_req_ready, 1'b1);
    d_read_cycle(16'h310, 1'b1, 1'b0, "cap rd at resp");
    check("cap wr mv", mem_req_valid, 1'b1);
    check("cap wr mt", mem_req_type, 1'b1);
    check("cap wr ma", mem_req_block_addr, 16'h2FF);
    check("cap wr md", mem_req_block_data, 32'h77);
    check("cap resp drv", dcache_resp_valid, 1'b1);
    d_read_cycle(16'h310, 1'b0, 1'b1, "cap rd after resp");
    @(negedge clk);
    idle_inputs();
    #1;
    check("cap rd mv", mem_req_valid, 1'b1);
    check("cap rd mt", mem_req_type, 1'b0);
    check("cap rd ma", mem_req_block_addr, 16'h310);
    drain(4);

    // Accept and response in the same cycle at two outstanding leaves the count at two.
    d_read_cycle(16'h400, 1'b0, 1'b1, "same rd0");
    d_read_cycle(16'h401, 1'b0, 1'b1, "same rd1");
    d_read_cycle(16'h402, 1'b1, 1'b1, "same rd+resp");
    d_read_cycle(16'h403, 1'b0, 1'b1, "same rd3");
    d_read_cycle(16'h404, 1'b0, 1'b1, "same rd4");
    d_read_cycle(16'h405, 1'b0, 1'b0, "same rd5 blocked");
    drain(4);

    // Response with nothing outstanding: routed, flags a sticky error cleared only by reset.
    @(negedge clk);
    idle_inputs();
    mem_resp_valid      = 1'b1;
    mem_resp_block_data = 32'h5A;
    #1;
    check("err routed", icache_resp_valid, 1'b1);
    check("err routed data", icache_resp_block_data, 32'h5A);
    check("err before edge", protocol_err, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("err set", protocol_err, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("err sticky", protocol_err, 1'b1);
    d_read_cycle(16'h500, 1'b0, 1'b1, "err no underflow rd");
    d_read_cycle(16'h501, 1'b0, 1'b1, "err no underflow rd1");
    d_read_cycle(16'h502, 1'b0, 1'b1, "err no underflow rd2");
    d_read_cycle(16'h503, 1'b0, 1'b1, "err no underflow rd3");
    d_read_cycle(16'h504, 1'b0, 1'b0, "err no underflow full");
    @(negedge clk);
    idle_inputs();
    rst_aL = 1'b0;
    #1;
    check("err cleared", protocol_err, 1'b0);
    @(negedge clk);
    rst_aL = 1'b1;

    // Reset lands in the cycle an icache read is accepted: the request must be dropped.
    @(negedge clk);
    idle_inputs();
    icache_req_valid      = 1'b1;
    icache_req_block_addr = 16'h3C;
    #1;
    check("rstacc ir pre", icache_req_ready, 1'b1);
    #2;
    rst_aL         = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    all_zero("rstacc");
    @(posedge clk);
    #1;
    check("rstacc mv edge", mem_req_valid, 1'b0);
    @(negedge clk);
    idle_inputs();
    rst_aL = 1'b1;
    #1;
    check("rstacc mv after", mem_req_valid, 1'b0);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    #1;
    check("rstacc mv later", mem_req_valid, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("rstacc count zero", protocol_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Arbitrates icache and dcache block requests onto the single latency-sensitive main_mem request channel.
- Tracks outstanding reads and routes main_mem responses back to the requesting cache by cache type.
- Sits between the core's cache miss interfaces and main_mem. It is a scheduling and arbitration alternative to the existing memory controller.
- Registered issue stage; one request per cycle maximum.

Parameters:
- ADDR_W, `MAIN_MEM_BLOCK_ADDR_WIDTH: block address width.
- DATA_W, `BLOCK_DATA_WIDTH: block data width.
- MAX_OUTSTANDING, 4: maximum in-flight reads (1..15).
- STARVE_LIMIT, 8: consecutive icache-waiting cycles before icache is forced to win (1..255).

Ports:
- clk  in  1  clock
- rst_aL  in  1  asynchronous active-low reset
- icache_req_valid  in  1  icache read request
- icache_req_block_addr  in  ADDR_W  icache block address
- icache_req_ready  out  1  icache request accepted this cycle
- dcache_req_valid  in  1  dcache request
- dcache_req_type  in  1  0 = read, 1 = write
- dcache_req_block_addr  in  ADDR_W  dcache block address
- dcache_req_block_data  in  DATA_W  write data
- dcache_req_ready  out  1  dcache request accepted this cycle
- mem_req_valid  out  1  request to main_mem (one-cycle pulse)
- mem_req_cache_type  out  1  0 = icache, 1 = dcache
- mem_req_type  out  1  0 = read, 1 = write
- mem_req_block_addr  out  ADDR_W  address to main_mem
- mem_req_block_data  out  DATA_W  write data to main_mem
- mem_resp_valid  in  1  main_mem read response
- mem_resp_cache_type  in  1  response owner
- mem_resp_block_data  in  DATA_W  response data
- icache_resp_valid  out  1  routed response to icache
- icache_resp_block_data  out  DATA_W  routed data
- dcache_resp_valid  out  1  routed response to dcache
- dcache_resp_block_data  out  DATA_W  routed data
- protocol_err  out  1  sticky error flag

Behaviour:
- Reset (rst_aL low, asynchronous):
  - All outputs 0, including ready signals and protocol_err.
  - outstanding counter = 0, starve counter = 0, state = ARB.
  - A request accepted in the cycle reset asserts is dropped; mem_req_valid is 0 on the following edge.
- Handshake:
  - A request is accepted when valid & ready are both high in the same cycle.
  - Ready is combinational from the grant and the capacity check. Only one of icache_req_ready / dcache_req_ready is ever high.
- Capacity:
  - Reads are blocked (ready = 0) when outstanding == MAX_OUTSTANDING.
  - A dcache write is never blocked by capacity. Writes produce no response and are not counted.
- Issue:
  - An accepted request is registered.
  - On the next cycle mem_req_valid = 1 for exactly one cycle, with cache_type, type, addr and data of the accepted request.
  - When no request is accepted, mem_req_valid = 0 and the other mem_req fields hold their last values.
- Outstanding counter:
  - +1 on an accepted read.
  - -1 on mem_resp_valid.
  - Both in the same cycle: unchanged.
- States:
  - ARB:
    - dcache has priority.
    - The starve counter increments each cycle icache_req_valid is high and the icache is not granted. It resets to 0 on an icache grant or when icache_req_valid is low.
    - starve counter reaches STARVE_LIMIT -> ICACHE_PRIO.
  - ICACHE_PRIO:
    - icache has priority.
    - On an icache grant (or icache_req_valid low): starve counter = 0, -> ARB.
  - If the prioritised requester is not valid, or is capacity-blocked (a read at full capacity), the other requester may be granted. A dcache write can therefore proceed while icache is blocked at full capacity.
- Response routing:
  - Combinational pass-through of mem_resp_valid and mem_resp_block_data.
  - mem_resp_cache_type = 0 drives the icache_resp pair; 1 drives the dcache_resp pair.
  - The non-selected resp_valid is 0.
- Errors:
  - mem_resp_valid while outstanding == 0 sets protocol_err (sticky until reset).
  - The response is still routed; the counter is not decremented below 0.

Optional Feature:
- Macro: MEM_REQ_ARB_RR_EN.
- Defined: the STARVE_LIMIT logic and ICACHE_PRIO state are removed. Arbitration is pure round-robin: a last-grant bit gives priority to the requester not granted last. The last-grant bit resets to icache-last, so dcache wins the first tie.
- Undefined: dcache priority with starvation escape, as in Behaviour.

Test Plan:
- Reset, then a single icache read to addr 0x10 -> icache_req_ready = 1 in the request cycle; mem_req_valid = 1, cache_type = 0, addr = 0x10 the next cycle. main_mem response with data 0xAB -> icache_resp_valid = 1, data = 0xAB, dcache_resp_valid = 0.
- icache and dcache both continuously valid (reads), MAX_OUTSTANDING = 15, responses returned promptly, STARVE_LIMIT = 8 -> dcache granted for 8 cycles, icache granted on the 9th, then dcache again. With MEM_REQ_ARB_RR_EN defined: strict alternation D, I, D, I.
- Issue 4 dcache reads with no responses, MAX_OUTSTANDING = 4 -> ready = 0 for the 5th read. A dcache write in the same condition -> accepted, mem_req_type = 1. A response arrives -> the read is accepted the next cycle.
- Read accept and mem_resp_valid in the same cycle at outstanding = 2 -> count stays 2, verified by the capacity boundary: exactly 2 further reads accepted, the next one blocked.
- mem_resp_valid with nothing outstanding -> protocol_err = 1 and stays 1; rst_aL pulse -> protocol_err = 0.
- rst_aL asserted in the cycle a request is accepted -> mem_req_valid stays 0 and all outputs are 0 during reset.
